// File: rtl/alu_src_sched.sv
// -----------------------------------------------------------------------------
// alu_src_sched
//
// Two-requester operand scheduler in front of an ALU. Each cycle at most one
// requester is granted. The winner's source operands are selected and
// registered into a single output slot, along with its destination tag.
// The slot uses a valid/ready handshake toward the ALU. A flush (kill)
// empties the slot and blocks issue for that cycle.
//
// Configuration macro:
//   ALU_SRC_SCHED_RR_EN  defined   -> round-robin arbitration between req0/req1
//                        undefined -> fixed priority, req0 always beats req1
//
// Parameters:
//   TAG_W            width of the destination tag carried with each op
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   reqN_valid       requester N holds a ready-to-issue op (N = 0, 1)
//   reqN_ready       requester N's op is accepted this cycle (combinational)
//   reqN_src_a_sel   operand A select (rs1 / pc / zero)
//   reqN_src_b_sel   operand B select (rs2 / imm / four / zero)
//   reqN_pc          program counter of the op
//   reqN_rs1/rs2/imm raw register and immediate operands
//   reqN_tag         destination tag
//   kill             pipeline flush
//   out_valid        output slot holds an op
//   out_ready        ALU accepts the slot contents this cycle
//   out_src_a/b      muxed operands
//   out_tag          destination tag of the slot op
//   out_gnt          index of the requester that supplied the slot op
// -----------------------------------------------------------------------------

`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef SRC_A_SEL_WIDTH
`define SRC_A_SEL_WIDTH 2
`endif
`ifndef SRC_B_SEL_WIDTH
`define SRC_B_SEL_WIDTH 2
`endif
`ifndef SRC_A_RS1
`define SRC_A_RS1 2'd0
`endif
`ifndef SRC_A_PC
`define SRC_A_PC 2'd1
`endif
`ifndef SRC_B_RS2
`define SRC_B_RS2 2'd0
`endif
`ifndef SRC_B_IMM
`define SRC_B_IMM 2'd1
`endif
`ifndef SRC_B_FOUR
`define SRC_B_FOUR 2'd2
`endif

module alu_src_sched #(
  parameter int TAG_W = 6
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [`SRC_A_SEL_WIDTH-1:0] req0_src_a_sel,
  input  logic [`SRC_B_SEL_WIDTH-1:0] req0_src_b_sel,
  input  logic [`ADDR_LEN-1:0]        req0_pc,
  input  logic [`DATA_LEN-1:0]        req0_rs1,
  input  logic [`DATA_LEN-1:0]        req0_rs2,
  input  logic [`DATA_LEN-1:0]        req0_imm,
  input  logic [TAG_W-1:0]            req0_tag,

  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [`SRC_A_SEL_WIDTH-1:0] req1_src_a_sel,
  input  logic [`SRC_B_SEL_WIDTH-1:0] req1_src_b_sel,
  input  logic [`ADDR_LEN-1:0]        req1_pc,
  input  logic [`DATA_LEN-1:0]        req1_rs1,
  input  logic [`DATA_LEN-1:0]        req1_rs2,
  input  logic [`DATA_LEN-1:0]        req1_imm,
  input  logic [TAG_W-1:0]            req1_tag,

  input  logic                        kill,

  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`DATA_LEN-1:0]        out_src_a,
  output logic [`DATA_LEN-1:0]        out_src_b,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        out_gnt
);

  // Operand A: register, PC (zero-extended to data width) or zero.
  function automatic logic [`DATA_LEN-1:0] mux_src_a(
    input logic [`SRC_A_SEL_WIDTH-1:0] sel,
    input logic [`DATA_LEN-1:0]        rs1,
    input logic [`ADDR_LEN-1:0]        pc
  );
    case (sel)
      `SRC_A_RS1: mux_src_a = rs1;
      `SRC_A_PC:  mux_src_a = `DATA_LEN'(pc);
      default:    mux_src_a = '0;
    endcase
  endfunction

  // Operand B: register, immediate, constant four (next-PC) or zero.
  function automatic logic [`DATA_LEN-1:0] mux_src_b(
    input logic [`SRC_B_SEL_WIDTH-1:0] sel,
    input logic [`DATA_LEN-1:0]        rs2,
    input logic [`DATA_LEN-1:0]        imm
  );
    case (sel)
      `SRC_B_RS2:  mux_src_b = rs2;
      `SRC_B_IMM:  mux_src_b = imm;
      `SRC_B_FOUR: mux_src_b = `DATA_LEN'(4);
      default:     mux_src_b = '0;
    endcase
  endfunction

  logic                 valid_q, valid_d;
  logic                 gnt_q,   gnt_d;
  logic [TAG_W-1:0]     tag_q,   tag_d;
  logic [`DATA_LEN-1:0] src_a_q, src_a_d;
  logic [`DATA_LEN-1:0] src_b_q, src_b_d;

  logic slot_free;
  logic can_issue;
  logic grant_any;
  logic pick1;

`ifdef ALU_SRC_SCHED_RR_EN
  logic prio_q, prio_d;
`endif

  // The slot can take a new op when empty or when its current op is being
  // consumed this cycle. Kill and reset both block issue outright.
  assign slot_free = !valid_q || out_ready;
  assign can_issue = slot_free && !kill && !reset;

`ifdef ALU_SRC_SCHED_RR_EN
  // prio names the requester that wins a tie; a lone requester always wins.
  assign pick1 = req1_valid && (!req0_valid || prio_q);
`else
  assign pick1 = req1_valid && !req0_valid;
`endif

  assign grant_any  = can_issue && (req0_valid || req1_valid);
  // When pick1 is low and a grant happens, req0 must be the valid one.
  assign req0_ready = grant_any && !pick1;
  assign req1_ready = grant_any &&  pick1;

  always_comb begin
    valid_d = valid_q;
    gnt_d   = gnt_q;
    tag_d   = tag_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
`ifdef ALU_SRC_SCHED_RR_EN
    prio_d  = prio_q;
`endif
    if (kill) begin
      // Flush drops the slot op; data fields keep their last value.
      valid_d = 1'b0;
    end else if (grant_any) begin
      valid_d = 1'b1;
      gnt_d   = pick1;
      if (pick1) begin
        tag_d   = req1_tag;
        src_a_d = mux_src_a(req1_src_a_sel, req1_rs1, req1_pc);
        src_b_d = mux_src_b(req1_src_b_sel, req1_rs2, req1_imm);
      end else begin
        tag_d   = req0_tag;
        src_a_d = mux_src_a(req0_src_a_sel, req0_rs1, req0_pc);
        src_b_d = mux_src_b(req0_src_b_sel, req0_rs2, req0_imm);
      end
`ifdef ALU_SRC_SCHED_RR_EN
      // Hand the tie-break to the requester that just lost.
      prio_d = !pick1;
`endif
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      gnt_q   <= 1'b0;
      tag_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
`ifdef ALU_SRC_SCHED_RR_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
      tag_q   <= tag_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
`ifdef ALU_SRC_SCHED_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_gnt   = gnt_q;
  assign out_tag   = tag_q;
  assign out_src_a = src_a_q;
  assign out_src_b = src_b_q;

endmodule

// File: tb/tb_alu_src_sched.sv
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef SRC_A_SEL_WIDTH
`define SRC_A_SEL_WIDTH 2
`endif
`ifndef SRC_B_SEL_WIDTH
`define SRC_B_SEL_WIDTH 2
`endif
`ifndef SRC_A_RS1
`define SRC_A_RS1 2'd0
`endif
`ifndef SRC_A_PC
`define SRC_A_PC 2'd1
`endif
`ifndef SRC_B_RS2
`define SRC_B_RS2 2'd0
`endif
`ifndef SRC_B_IMM
`define SRC_B_IMM 2'd1
`endif
`ifndef SRC_B_FOUR
`define SRC_B_FOUR 2'd2
`endif

module tb_alu_src_sched;

  localparam int TAG_W = 6;
`ifdef ALU_SRC_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic kill;
  logic out_ready;

  logic                        vld  [2];
  logic [`SRC_A_SEL_WIDTH-1:0] asel [2];
  logic [`SRC_B_SEL_WIDTH-1:0] bsel [2];
  logic [`ADDR_LEN-1:0]        pc   [2];
  logic [`DATA_LEN-1:0]        rs1  [2];
  logic [`DATA_LEN-1:0]        rs2  [2];
  logic [`DATA_LEN-1:0]        imm  [2];
  logic [TAG_W-1:0]            tag  [2];

  logic                 req0_ready, req1_ready;
  logic                 out_valid, out_gnt;
  logic [`DATA_LEN-1:0] out_src_a, out_src_b;
  logic [TAG_W-1:0]     out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the slot as a plain record plus the tie-break owner.
  bit                   m_valid;
  bit                   m_gnt;
  int                   m_prio;
  logic [TAG_W-1:0]     m_tag;
  logic [`DATA_LEN-1:0] m_a, m_b;

  alu_src_sched #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(vld[0]), .req0_ready(req0_ready),
    .req0_src_a_sel(asel[0]), .req0_src_b_sel(bsel[0]),
    .req0_pc(pc[0]), .req0_rs1(rs1[0]), .req0_rs2(rs2[0]), .req0_imm(imm[0]),
    .req0_tag(tag[0]),
    .req1_valid(vld[1]), .req1_ready(req1_ready),
    .req1_src_a_sel(asel[1]), .req1_src_b_sel(bsel[1]),
    .req1_pc(pc[1]), .req1_rs1(rs1[1]), .req1_rs2(rs2[1]), .req1_imm(imm[1]),
    .req1_tag(tag[1]),
    .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src_a(out_src_a), .out_src_b(out_src_b),
    .out_tag(out_tag), .out_gnt(out_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic logic [`DATA_LEN-1:0] ref_a(input logic [`SRC_A_SEL_WIDTH-1:0] s,
                                                  input logic [`DATA_LEN-1:0] r,
                                                  input logic [`ADDR_LEN-1:0] p);
    if (s == `SRC_A_RS1) return r;
    if (s == `SRC_A_PC)  return `DATA_LEN'(p);
    return '0;
  endfunction

  function automatic logic [`DATA_LEN-1:0] ref_b(input logic [`SRC_B_SEL_WIDTH-1:0] s,
                                                  input logic [`DATA_LEN-1:0] r,
                                                  input logic [`DATA_LEN-1:0] i);
    if (s == `SRC_B_RS2)  return r;
    if (s == `SRC_B_IMM)  return i;
    if (s == `SRC_B_FOUR) return `DATA_LEN'(4);
    return '0;
  endfunction

  // Which requester the rules say is granted now (-1 = none).
  function automatic int model_grant();
    if (reset || kill) return -1;
    if (m_valid && !out_ready) return -1;
    if (vld[0] && vld[1]) return RR ? m_prio : 0;
    if (vld[0]) return 0;
    if (vld[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_gnt = 0; m_prio = 0; m_tag = '0; m_a = '0; m_b = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_gnt",   64'(out_gnt),   64'(m_gnt));
    chk("out_tag",   64'(out_tag),   64'(m_tag));
    chk("out_src_a", 64'(out_src_a), 64'(m_a));
    chk("out_src_b", 64'(out_src_b), 64'(m_b));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next
  // falling edge.
  task automatic step();
    int g;
    #1;
    g = model_grant();
    chk("req0_ready", 64'(req0_ready), 64'(g == 0));
    chk("req1_ready", 64'(req1_ready), 64'(g == 1));
    @(posedge clk);
    if (kill) m_valid = 0;
    else if (g >= 0) begin
      m_valid = 1;
      m_gnt   = g[0];
      m_tag   = tag[g];
      m_a     = ref_a(asel[g], rs1[g], pc[g]);
      m_b     = ref_b(bsel[g], rs2[g], imm[g]);
      m_prio  = RR ? 1 - g : 0;
    end else if (m_valid && out_ready) m_valid = 0;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      vld[i] = 0; asel[i] = '0; bsel[i] = '0; pc[i] = '0;
      rs1[i] = '0; rs2[i] = '0; imm[i] = '0; tag[i] = '0;
    end
  endtask

  initial begin
    int exp_seq [4];
    reset = 1; kill = 0; out_ready = 0;
    clear_reqs();
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 0;

    // Contention: both requesters hold ops, ALU always ready.
    for (int i = 0; i < 4; i++) exp_seq[i] = RR ? (i % 2) : 0;
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1; asel[i] = `SRC_A_RS1; bsel[i] = `SRC_B_RS2;
      rs1[i] = 32'h1000 + i; rs2[i] = 32'h2000 + i; tag[i] = TAG_W'(10 + i);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cont_gnt", 64'(out_gnt), 64'(exp_seq[i]));
    end
    clear_reqs();

    // Single op from req0: PC + 4.
    vld[0] = 1; asel[0] = `SRC_A_PC; pc[0] = 'h100; bsel[0] = `SRC_B_FOUR; tag[0] = 5;
    step();
    chk("single_a",   64'(out_src_a), 64'h100);
    chk("single_b",   64'(out_src_b), 64'd4);
    chk("single_tag", 64'(out_tag),   64'd5);
    chk("single_gnt", 64'(out_gnt),   64'd0);
    clear_reqs();

    // Stall for three cycles with req1 waiting, then release.
    out_ready = 0;
    vld[1] = 1; asel[1] = `SRC_A_RS1; bsel[1] = `SRC_B_RS2;
    rs1[1] = 32'hDEAD; rs2[1] = 32'hBEEF; tag[1] = 7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_a", 64'(out_src_a), 64'h100);
    end
    out_ready = 1;
    step();
    chk("unstall_a",   64'(out_src_a), 64'hDEAD);
    chk("unstall_b",   64'(out_src_b), 64'hBEEF);
    chk("unstall_gnt", 64'(out_gnt),   64'd1);
    clear_reqs();

    // Kill beats a ready ALU and a pending request.
    vld[0] = 1; asel[0] = `SRC_A_RS1; rs1[0] = 32'h55; tag[0] = 3;
    kill = 1;
    step();
    chk("kill_valid", 64'(out_valid), 64'd0);
    kill = 0;
    step();
    chk("after_kill_valid", 64'(out_valid), 64'd1);
    chk("after_kill_a",     64'(out_src_a), 64'h55);

    // Unused select encodings yield zero operands.
    asel[0] = `SRC_A_SEL_WIDTH'(3); bsel[0] = `SRC_B_SEL_WIDTH'(3);
    rs1[0] = '1; rs2[0] = '1; imm[0] = '1; pc[0] = '1;
    step();
    chk("illegal_a", 64'(out_src_a), 64'd0);
    chk("illegal_b", 64'(out_src_b), 64'd0);

    // Asynchronous reset in the middle of a stall.
    out_ready = 0; vld[0] = 1; vld[1] = 1;
    step();
    #2 reset = 1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_rdy0", 64'(req0_ready), 64'd0);
    chk("rst_rdy1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    reset = 0;
    clear_reqs();

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 2; i++) begin
        vld[i]  = ($urandom_range(0, 2) != 0);
        asel[i] = `SRC_A_SEL_WIDTH'($urandom);
        bsel[i] = `SRC_B_SEL_WIDTH'($urandom);
        pc[i]   = `ADDR_LEN'($urandom);
        rs1[i]  = `DATA_LEN'($urandom);
        rs2[i]  = `DATA_LEN'($urandom);
        imm[i]  = `DATA_LEN'($urandom);
        tag[i]  = TAG_W'($urandom);
      end
      kill      = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
